// File: rtl/console_rx_fifo.sv
// console_rx_fifo: 8N1 console UART receiver feeding a byte FIFO that the
// CPU polls through reg_dat_re / reg_dat_do. An empty FIFO reads as 0.
// Optional feature macro: CONSOLE_RX_FRAMING_CHECK_EN. When defined, bytes with a
// bad stop bit are dropped and counted on rx_frame_err.
module console_rx_fifo #(
   parameter int          DEPTH_LOG2  = 4,
   parameter logic [31:0] DEFAULT_DIV = 32'd53333
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  ser_rx,
   input  logic [3:0]            reg_div_we,
   input  logic [31:0]           reg_div_di,
   output logic [31:0]           reg_div_do,
   input  logic                  reg_dat_re,
   output logic [31:0]           reg_dat_do,
   output logic [DEPTH_LOG2:0]   rx_level,
   output logic                  rx_overrun
`ifdef CONSOLE_RX_FRAMING_CHECK_EN
   ,
   output logic [7:0]            rx_frame_err
`endif
);

   localparam int DEPTH = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0] LEVEL_ONE  = (DEPTH_LOG2 + 1)'(1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_DATA  = 2'd2;
   localparam logic [1:0] ST_STOP  = 2'd3;

   logic                  rx_meta_reg, rx_sync_reg, rx_prev_reg;
   logic [7:0]            div_lane_reg [4];
   logic [31:0]           div_reg, div_eff;
   logic [31:0]           frame_div_reg, frame_div_next;
   logic [31:0]           timer_reg, timer_next;
   logic [1:0]            state_reg, state_next;
   logic [2:0]            bit_idx_reg, bit_idx_next;
   logic [7:0]            shift_reg, shift_next;
   logic                  push_req;
   logic                  frame_err_evt;

   logic [7:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [DEPTH_LOG2:0]   level_reg;
   logic                  overrun_reg;
   logic                  fifo_empty, fifo_full, pop, push_ok, overflow;

   // Two-flop synchroniser plus one delay flop for falling-edge detection
   always_ff @(posedge clk) begin
      if (!resetn) begin
         rx_meta_reg <= 1'b1;
         rx_sync_reg <= 1'b1;
         rx_prev_reg <= 1'b1;
      end else begin
         rx_meta_reg <= ser_rx;
         rx_sync_reg <= rx_meta_reg;
         rx_prev_reg <= rx_sync_reg;
      end
   end

   // Divider register, one independently writable byte lane per generate slot
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_div_lane
         always_ff @(posedge clk) begin
            if (!resetn)
               div_lane_reg[gi] <= DEFAULT_DIV[gi*8 +: 8];
            else if (reg_div_we[gi])
               div_lane_reg[gi] <= reg_div_di[gi*8 +: 8];
         end
         assign div_reg[gi*8 +: 8] = div_lane_reg[gi];
      end
   endgenerate

   assign div_eff    = (div_reg < 32'd2) ? 32'd2 : div_reg;
   assign reg_div_do = div_reg;

   // Receiver next-state logic; the divider is frozen per frame at the start edge
   always_comb begin
      state_next     = state_reg;
      timer_next     = timer_reg;
      bit_idx_next   = bit_idx_reg;
      shift_next     = shift_reg;
      frame_div_next = frame_div_reg;
      push_req       = 1'b0;
      frame_err_evt  = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (rx_prev_reg && !rx_sync_reg) begin
               frame_div_next = div_eff;
               timer_next     = div_eff >> 1;
               state_next     = ST_START;
            end
         end
         ST_START: begin
            if (timer_reg == 32'd0) begin
               if (rx_sync_reg) begin
                  state_next = ST_IDLE;
               end else begin
                  timer_next   = frame_div_reg - 32'd1;
                  bit_idx_next = 3'd0;
                  state_next   = ST_DATA;
               end
            end else begin
               timer_next = timer_reg - 32'd1;
            end
         end
         ST_DATA: begin
            if (timer_reg == 32'd0) begin
               shift_next = {rx_sync_reg, shift_reg[7:1]};
               timer_next = frame_div_reg - 32'd1;
               if (bit_idx_reg == 3'd7)
                  state_next = ST_STOP;
               else
                  bit_idx_next = bit_idx_reg + 3'd1;
            end else begin
               timer_next = timer_reg - 32'd1;
            end
         end
         default: begin
            if (timer_reg == 32'd0) begin
               state_next = ST_IDLE;
`ifdef CONSOLE_RX_FRAMING_CHECK_EN
               push_req      = rx_sync_reg;
               frame_err_evt = !rx_sync_reg;
`else
               push_req      = 1'b1;
`endif
            end else begin
               timer_next = timer_reg - 32'd1;
            end
         end
      endcase
   end

   // Receiver state registers; reset aborts any frame in progress
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_reg     <= ST_IDLE;
         timer_reg     <= 32'd0;
         bit_idx_reg   <= 3'd0;
         shift_reg     <= 8'd0;
         frame_div_reg <= 32'd0;
      end else begin
         state_reg     <= state_next;
         timer_reg     <= timer_next;
         bit_idx_reg   <= bit_idx_next;
         shift_reg     <= shift_next;
         frame_div_reg <= frame_div_next;
      end
   end

   assign fifo_empty = (level_reg == '0);
   assign fifo_full  = (level_reg == FULL_LEVEL);
   assign pop        = reg_dat_re && !fifo_empty;
   assign push_ok    = push_req && (!fifo_full || pop);
   assign overflow   = push_req && fifo_full && !pop;

   // FIFO storage; a simultaneous pop frees the slot so a full FIFO still accepts
   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr_reg] <= shift_reg;
   end

   // FIFO pointers, fill level and sticky overrun (set beats clear)
   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr_reg  <= '0;
         rd_ptr_reg  <= '0;
         level_reg   <= '0;
         overrun_reg <= 1'b0;
      end else begin
         if (push_ok)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         if (push_ok && !pop)
            level_reg <= level_reg + LEVEL_ONE;
         else if (pop && !push_ok)
            level_reg <= level_reg - LEVEL_ONE;
         if (overflow)
            overrun_reg <= 1'b1;
         else if (pop)
            overrun_reg <= 1'b0;
      end
   end

   assign reg_dat_do = fifo_empty ? 32'h0 : {24'h0, mem[rd_ptr_reg]};
   assign rx_level   = level_reg;
   assign rx_overrun = overrun_reg;

`ifdef CONSOLE_RX_FRAMING_CHECK_EN
   logic [7:0] frame_err_reg;

   // Saturating count of frames whose stop bit sampled low
   always_ff @(posedge clk) begin
      if (!resetn)
         frame_err_reg <= 8'd0;
      else if (frame_err_evt && frame_err_reg != 8'hFF)
         frame_err_reg <= frame_err_reg + 8'd1;
   end

   assign rx_frame_err = frame_err_reg;
`endif

endmodule

// File: tb/tb_console_rx_fifo.sv
// tb_console_rx_fifo: scoreboard bench for console_rx_fifo with a 16-clock bit time.
module tb_console_rx_fifo;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        ser_rx = 1'b1;
   logic [3:0]  reg_div_we = 4'h0;
   logic [31:0] reg_div_di = 32'h0;
   logic [31:0] reg_div_do;
   logic        reg_dat_re = 1'b0;
   logic [31:0] reg_dat_do;
   logic [4:0]  rx_level;
   logic        rx_overrun;
`ifdef CONSOLE_RX_FRAMING_CHECK_EN
   logic [7:0]  rx_frame_err;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0] exp_q [$];

   always #5 clk = ~clk;

   console_rx_fifo #(.DEPTH_LOG2(4), .DEFAULT_DIV(32'd16)) dut (
      .clk(clk), .resetn(resetn), .ser_rx(ser_rx),
      .reg_div_we(reg_div_we), .reg_div_di(reg_div_di), .reg_div_do(reg_div_do),
      .reg_dat_re(reg_dat_re), .reg_dat_do(reg_dat_do),
      .rx_level(rx_level), .rx_overrun(rx_overrun)
`ifdef CONSOLE_RX_FRAMING_CHECK_EN
      , .rx_frame_err(rx_frame_err)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         $display("ok   %s: %h", tag, got);
      end
   endtask

   // Drive one 8N1 frame at div clocks per bit, then a short idle gap
   task automatic send_byte(input logic [7:0] b, input int div, input logic stop_lvl);
      logic [9:0] frame;
      frame = {stop_lvl, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         @(negedge clk) ser_rx = frame[i];
         repeat (div - 1) @(negedge clk);
      end
      @(negedge clk) ser_rx = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   // Send a byte and record its expected acceptance in the scoreboard
   task automatic send_exp(input logic [7:0] b, input int div);
      if (exp_q.size() < 16) exp_q.push_back(b);
      send_byte(b, div, 1'b1);
   endtask

   // Compare level and head against the scoreboard, then pop one entry
   task automatic read_check(input string tag);
      logic [31:0] exp_dat;
      exp_dat = (exp_q.size() != 0) ? {24'h0, exp_q[0]} : 32'h0;
      check({tag, ".level"}, {27'h0, rx_level}, exp_q.size());
      check({tag, ".dat"}, reg_dat_do, exp_dat);
      @(negedge clk) reg_dat_re = 1'b1;
      @(negedge clk) reg_dat_re = 1'b0;
      if (exp_q.size() != 0) void'(exp_q.pop_front());
   endtask

   task automatic write_div(input logic [31:0] v);
      @(negedge clk) begin reg_div_we = 4'hF; reg_div_di = v; end
      @(negedge clk) reg_div_we = 4'h0;
   endtask

   initial begin
      repeat (5) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      check("rst.div", reg_div_do, 32'd16);
      check("rst.dat", reg_dat_do, 32'h0);
      check("rst.level", {27'h0, rx_level}, 32'd0);
      check("rst.overrun", {31'h0, rx_overrun}, 32'd0);

      // single byte then read back to empty
      send_exp(8'h41, 16);
      read_check("byte41");
      check("byte41.after.dat", reg_dat_do, 32'h0);
      check("byte41.after.level", {27'h0, rx_level}, 32'd0);

      // read on empty is ignored
      @(negedge clk) reg_dat_re = 1'b1;
      @(negedge clk) reg_dat_re = 1'b0;
      check("empty_re.level", {27'h0, rx_level}, 32'd0);

      // short low glitch is a false start
      @(negedge clk) ser_rx = 1'b0;
      repeat (3) @(negedge clk);
      ser_rx = 1'b1;
      repeat (40) @(negedge clk);
      check("glitch.level", {27'h0, rx_level}, 32'd0);
      send_exp(8'hA7, 16);
      read_check("after_glitch");

      // overflow: 17 bytes into a 16-deep FIFO
      for (int i = 0; i <= 16; i++) send_exp(8'(i), 16);
      check("ovf.level", {27'h0, rx_level}, 32'd16);
      check("ovf.overrun", {31'h0, rx_overrun}, 32'd1);
      for (int i = 0; i < 16; i++) begin
         read_check($sformatf("ovf.rd%0d", i));
         if (i == 0) check("ovf.overrun_clr", {31'h0, rx_overrun}, 32'd0);
      end
      check("ovf.drained", {27'h0, rx_level}, 32'd0);

      // divider written mid-frame only applies from the next frame
      exp_q.push_back(8'h5A);
      fork
         send_byte(8'h5A, 16, 1'b1);
         begin
            repeat (50) @(negedge clk);
            write_div(32'd32);
         end
      join
      check("div.readback", reg_div_do, 32'd32);
      read_check("div.frame16");
      send_exp(8'hC3, 32);
      read_check("div.frame32");
      write_div(32'd16);

      // stop bit held low
      send_byte(8'h55, 16, 1'b0);
      repeat (20) @(negedge clk);
`ifdef CONSOLE_RX_FRAMING_CHECK_EN
      check("ferr.count", {24'h0, rx_frame_err}, 32'd1);
      check("ferr.level", {27'h0, rx_level}, 32'd0);
`else
      exp_q.push_back(8'h55);
      read_check("ferr.pushed");
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
